// File: rtl/store_write_buffer.sv
// Store write buffer for the 32-bit MIPS datapath.
// Formats sb/sh/sw stores into byte lanes and queues them in a small FIFO.
// A two-state FSM drains the FIFO to data memory over a MemReq/MemAck handshake.
// Loads that hit a queued, not-yet-written word are stalled.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic [1:0]       StoreSize,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  input  logic             MemRead,
  input  logic [31:0]      LoadAddress,
  output logic             StoreAccept,
  output logic             Stall,
  output logic             AlignError,
  output logic             MemReq,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWData,
  output logic [3:0]       MemByteEn,
  input  logic             MemAck,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] Count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Queue storage; only the word address is kept, the low two bits are always zero.
  logic [29:0] entryAddr [DEPTH];
  logic [31:0] entryData [DEPTH];
  logic [3:0]  entryBe   [DEPTH];

  logic [PTR_W-1:0] headPtr_q, tailPtr_q, nextHeadPtr;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;

  logic        memReq_d;
  logic [31:0] memAddr_d, memWData_d;
  logic [3:0]  memByteEn_d;

  logic        aligned, push, pop, loadHit;
  logic [31:0] fmtData;
  logic [3:0]  fmtBe;

  assign Full        = (count_q == CNT_W'(DEPTH));
  assign Empty       = (count_q == '0);
  assign Count       = count_q;
  assign nextHeadPtr = headPtr_q + PTR_W'(1);

  // Full is the start-of-cycle value, so a same-cycle pop never frees a slot for this push.
  assign push        = MemWrite & aligned & ~Full;
  assign StoreAccept = push;
  assign Stall       = (MemWrite & aligned & Full) | loadHit;

  // Alignment check and little-endian lane formatting of the incoming store
  always_comb begin
    aligned = 1'b1;
    fmtData = WriteData;
    fmtBe   = 4'b1111;
    unique case (StoreSize)
      2'b00: begin
        fmtData = {4{WriteData[7:0]}};
        fmtBe   = 4'b0001 << Address[1:0];
      end
      2'b01: begin
        aligned = ~Address[0];
        fmtData = {2{WriteData[15:0]}};
        fmtBe   = Address[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: aligned = (Address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Load hazard: compare the load word address against every occupied slot
  always_comb begin
    logic [PTR_W-1:0] idx;
    loadHit = 1'b0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entryAddr[idx] == LoadAddress[31:2])) begin
        loadHit = 1'b1;
      end
    end
    loadHit = loadHit & MemRead;
  end

  // Drain FSM next state and next values of the registered memory interface
  always_comb begin
    state_d     = state_q;
    memReq_d    = MemReq;
    memAddr_d   = MemAddr;
    memWData_d  = MemWData;
    memByteEn_d = MemByteEn;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!Empty) begin
          memReq_d    = 1'b1;
          memAddr_d   = {entryAddr[headPtr_q], 2'b00};
          memWData_d  = entryData[headPtr_q];
          memByteEn_d = entryBe[headPtr_q];
          state_d     = StReq;
        end
      end
      StReq: begin
        if (MemAck) begin
          pop = 1'b1;
          if (count_q > CNT_W'(1)) begin
            memAddr_d   = {entryAddr[nextHeadPtr], 2'b00};
            memWData_d  = entryData[nextHeadPtr];
            memByteEn_d = entryBe[nextHeadPtr];
          end else if (push) begin
            // Queue would go empty but a store lands this edge: forward it without a bubble.
            memAddr_d   = {Address[31:2], 2'b00};
            memWData_d  = fmtData;
            memByteEn_d = fmtBe;
          end else begin
            memReq_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
    endcase
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // State, pointers, occupancy and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      headPtr_q  <= '0;
      tailPtr_q  <= '0;
      count_q    <= '0;
      MemReq     <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      MemByteEn  <= '0;
      AlignError <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      MemReq     <= memReq_d;
      MemAddr    <= memAddr_d;
      MemWData   <= memWData_d;
      MemByteEn  <= memByteEn_d;
      AlignError <= MemWrite & ~aligned;
      if (pop) headPtr_q <= nextHeadPtr;
      if (push) tailPtr_q <= tailPtr_q + PTR_W'(1);
    end
  end

  // Entry storage write; occupancy alone decides which slots are meaningful
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[tailPtr_q] <= Address[31:2];
      entryData[tailPtr_q] <= fmtData;
      entryBe[tailPtr_q]   <= fmtBe;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             MemWrite;
  logic [1:0]       StoreSize;
  logic [31:0]      Address;
  logic [31:0]      WriteData;
  logic             MemRead;
  logic [31:0]      LoadAddress;
  logic             StoreAccept;
  logic             Stall;
  logic             AlignError;
  logic             MemReq;
  logic [31:0]      MemAddr;
  logic [31:0]      MemWData;
  logic [3:0]       MemByteEn;
  logic             MemAck;
  logic             Full;
  logic             Empty;
  logic [CNT_W-1:0] Count;

  int checks = 0;
  int errors = 0;

  store_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .StoreSize(StoreSize),
    .Address(Address), .WriteData(WriteData), .MemRead(MemRead),
    .LoadAddress(LoadAddress), .StoreAccept(StoreAccept), .Stall(Stall),
    .AlignError(AlignError), .MemReq(MemReq), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemByteEn(MemByteEn), .MemAck(MemAck), .Full(Full), .Empty(Empty), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued stores in order, whether the head is being presented,
  // and the pending alignment-error pulse.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   mPres;
  bit   mAlign;

  function automatic bit isAligned(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0: return 1'b1;
      2'd1: return (a % 2) == 0;
      2'd2: return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelData(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] lo8, lo16;
    lo8  = wd & 32'h0000_00FF;
    lo16 = wd & 32'h0000_FFFF;
    if (sz == 2'd0) return lo8 * 32'h0101_0101;
    if (sz == 2'd1) return lo16 * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic bit modelHit(input logic [31:0] la);
    foreach (mq[i]) if ((mq[i].addr >> 2) == (la >> 2)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic mw, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic mr, input logic [31:0] la,
                       input logic ack);
    MemWrite = mw; StoreSize = sz; Address = a; WriteData = wd;
    MemRead = mr; LoadAddress = la; MemAck = ack;
    #1;
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    bit   wasPres, acked, accept, misal;
    int   preSize;
    ent_t e;
    preSize = mq.size();
    wasPres = mPres;
    acked   = mPres && (MemAck === 1'b1);
    accept  = MemWrite && isAligned(StoreSize, Address) && (preSize < DEPTH);
    misal   = MemWrite && !isAligned(StoreSize, Address);
    e.addr  = Address & 32'hFFFF_FFFC;
    e.data  = modelData(StoreSize, WriteData);
    e.be    = modelBe(StoreSize, Address);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mPres  = 1'b0;
      mAlign = 1'b0;
    end else begin
      if (acked) void'(mq.pop_front());
      if (accept) mq.push_back(e);
      if (wasPres) mPres = acked ? (mq.size() > 0) : 1'b1;
      else mPres = (preSize > 0);
      mAlign = misal;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (MemReq !== 1'b0) begin errors++;
      $display("FAIL reset_memreq: got %b expected 0", MemReq); end
    checks++; if ({MemAddr, MemWData, MemByteEn} !== 68'h0) begin errors++;
      $display("FAIL reset_outputs: got %h %h %h expected zeros", MemAddr, MemWData, MemByteEn); end
    checks++; if ({AlignError, Empty, Full, Count} !== {3'b010, 3'd0}) begin errors++;
      $display("FAIL reset_flags: got ae=%b e=%b f=%b c=%0d expected 0 1 0 0",
               AlignError, Empty, Full, Count); end
    // Reset while a request is outstanding and no ack arrives
    drive(1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h10) begin errors++;
      $display("FAIL reset_prereq: got req=%b addr=%h expected 1 00000010", MemReq, MemAddr); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (MemReq !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1) begin errors++;
      $display("FAIL reset_midreq: got req=%b cnt=%0d empty=%b expected 0 0 1",
               MemReq, Count, Empty); end
    tick(); tick();
    checks++; if (MemReq !== 1'b0) begin errors++;
      $display("FAIL reset_noreq_after: got %b expected 0", MemReq); end
  endtask

  task automatic test_lane_format();
    do_reset();
    drive(1, 2'd0, 32'h103, 32'h0000_00AB, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h100 || MemWData !== 32'hABABABAB
        || MemByteEn !== 4'b1000) begin errors++;
      $display("FAIL lane_sb: got req=%b %h %h %b expected 1 00000100 abababab 1000",
               MemReq, MemAddr, MemWData, MemByteEn); end
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    tick();
    checks++; if (MemReq !== 1'b0) begin errors++;
      $display("FAIL lane_sb_done: got req=%b expected 0", MemReq); end
    drive(1, 2'd1, 32'h202, 32'h0000_1234, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h200 || MemWData !== 32'h12341234
        || MemByteEn !== 4'b1100) begin errors++;
      $display("FAIL lane_sh: got req=%b %h %h %b expected 1 00000200 12341234 1100",
               MemReq, MemAddr, MemWData, MemByteEn); end
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    tick();
    checks++; if (MemReq !== 1'b0 || Empty !== 1'b1) begin errors++;
      $display("FAIL lane_sh_done: got req=%b empty=%b expected 0 1", MemReq, Empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 2'd2, 32'h0, 32'h1111_1111, 0, 0, 1);
    tick();
    checks++; if (MemReq !== 1'b0) begin errors++;
      $display("FAIL b2b_first_latency: got req=%b expected 0", MemReq); end
    for (int i = 1; i <= 4; i++) begin
      if (i <= 2) drive(1, 2'd2, 32'(4 * i), 32'(i), 0, 0, 1);
      else drive(0, 2'd0, 0, 0, 0, 0, 1);
      tick();
      checks++;
      if (i <= 3 && (MemReq !== 1'b1 || MemAddr !== 32'(4 * (i - 1)))) begin errors++;
        $display("FAIL b2b_req%0d: got req=%b addr=%h expected 1 %h",
                 i, MemReq, MemAddr, 32'(4 * (i - 1))); end
      else if (i == 4 && (MemReq !== 1'b0 || Empty !== 1'b1)) begin errors++;
        $display("FAIL b2b_end: got req=%b empty=%b expected 0 1", MemReq, Empty); end
    end
  endtask

  task automatic test_full_wrap();
    int          expIdx;
    logic [31:0] nextPush;
    logic        mw;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 2'd2, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0, 0);
      tick();
    end
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    checks++;
    if (Full !== 1'b1 || Count !== 3'd4 || MemReq !== 1'b1 || MemAddr !== 32'h100) begin
      errors++;
      $display("FAIL full_state: got f=%b c=%0d req=%b addr=%h expected 1 4 1 00000100",
               Full, Count, MemReq, MemAddr); end
    drive(1, 2'd2, 32'h110, 32'hA4, 0, 0, 1);
    checks++; if (Stall !== 1'b1 || StoreAccept !== 1'b0) begin errors++;
      $display("FAIL full_push_ack: got stall=%b acc=%b expected 1 0", Stall, StoreAccept); end
    tick();
    checks++; if (Count !== 3'd3 || MemAddr !== 32'h104) begin errors++;
      $display("FAIL full_after_pop: got c=%0d addr=%h expected 3 00000104", Count, MemAddr); end
    drive(1, 2'd2, 32'h110, 32'hA4, 0, 0, 0);
    checks++; if (StoreAccept !== 1'b1 || Stall !== 1'b0) begin errors++;
      $display("FAIL full_retry: got acc=%b stall=%b expected 1 0", StoreAccept, Stall); end
    tick();
    checks++; if (Count !== 3'd4) begin errors++;
      $display("FAIL full_refill: got c=%0d expected 4", Count); end
    nextPush = 32'h114;
    expIdx   = 1;
    for (int k = 0; k < 7; k++) begin
      mw = (nextPush <= 32'h11C) && (mq.size() < DEPTH);
      drive(mw, 2'd2, nextPush, nextPush, 0, 0, 1);
      tick();
      if (mw) nextPush += 4;
      expIdx++;
      checks++;
      if (expIdx < 8 && (MemReq !== 1'b1 || MemAddr !== 32'h100 + 32'(4 * expIdx))) begin
        errors++;
        $display("FAIL wrap_order%0d: got req=%b addr=%h expected 1 %h",
                 expIdx, MemReq, MemAddr, 32'h100 + 32'(4 * expIdx)); end
      else if (expIdx == 8 && (MemReq !== 1'b0 || Empty !== 1'b1)) begin errors++;
        $display("FAIL wrap_end: got req=%b empty=%b expected 0 1", MemReq, Empty); end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(1, 2'd2, 32'h6, 32'h55, 0, 0, 0);
    checks++; if (StoreAccept !== 1'b0 || Stall !== 1'b0) begin errors++;
      $display("FAIL misal_sw_comb: got acc=%b stall=%b expected 0 0", StoreAccept, Stall); end
    tick();
    checks++; if (AlignError !== 1'b1 || Count !== 3'd0 || MemReq !== 1'b0) begin errors++;
      $display("FAIL misal_sw: got ae=%b c=%0d req=%b expected 1 0 0", AlignError, Count, MemReq); end
    drive(1, 2'd1, 32'h1, 32'h66, 0, 0, 0);
    tick();
    checks++; if (AlignError !== 1'b1 || Count !== 3'd0) begin errors++;
      $display("FAIL misal_sh: got ae=%b c=%0d expected 1 0", AlignError, Count); end
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (AlignError !== 1'b0 || MemReq !== 1'b0) begin errors++;
      $display("FAIL misal_pulse_end: got ae=%b req=%b expected 0 0", AlignError, MemReq); end
  endtask

  task automatic test_load_hazard();
    do_reset();
    drive(1, 2'd2, 32'h40, 32'h77, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 1, 32'h42, 0);
    checks++; if (Stall !== 1'b1) begin errors++;
      $display("FAIL hazard_hit: got %b expected 1", Stall); end
    tick();
    checks++; if (Stall !== 1'b1) begin errors++;
      $display("FAIL hazard_hold: got %b expected 1", Stall); end
    drive(0, 2'd0, 0, 0, 1, 32'h42, 1);
    checks++; if (Stall !== 1'b1) begin errors++;
      $display("FAIL hazard_ack_cycle: got %b expected 1", Stall); end
    tick();
    drive(0, 2'd0, 0, 0, 1, 32'h42, 0);
    checks++; if (Stall !== 1'b0) begin errors++;
      $display("FAIL hazard_release: got %b expected 0", Stall); end
    drive(1, 2'd2, 32'h40, 32'h78, 0, 0, 0);
    tick();
    drive(0, 2'd0, 0, 0, 1, 32'h44, 0);
    checks++; if (Stall !== 1'b0) begin errors++;
      $display("FAIL hazard_other_word: got %b expected 0", Stall); end
  endtask

  task automatic test_random();
    logic        mw, mr, ack, expStall, expAcc;
    logic [1:0]  sz;
    logic [31:0] a, la, wd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      mw  = ($urandom_range(0, 99) < 55);
      sz  = 2'($urandom_range(0, 3));
      a   = ($urandom & 32'h8000_0000) | 32'($urandom_range(0, 31));
      wd  = $urandom;
      mr  = ($urandom_range(0, 99) < 35);
      la  = ($urandom & 32'h8000_0000) | 32'($urandom_range(0, 31));
      ack = ($urandom_range(0, 99) < 40);
      drive(mw, sz, a, wd, mr, la, ack);
      expAcc   = mw && isAligned(sz, a) && (mq.size() < DEPTH);
      expStall = (mw && isAligned(sz, a) && (mq.size() == DEPTH)) || (mr && modelHit(la));
      checks++;
      if (StoreAccept !== expAcc || Stall !== expStall) begin errors++;
        $display("FAIL rnd_comb@%0d: got acc=%b stall=%b expected %b %b",
                 n, StoreAccept, Stall, expAcc, expStall); end
      checks++;
      if (Count !== CNT_W'(mq.size()) || Full !== (mq.size() == DEPTH)
          || Empty !== (mq.size() == 0)) begin errors++;
        $display("FAIL rnd_count@%0d: got c=%0d f=%b e=%b expected c=%0d",
                 n, Count, Full, Empty, mq.size()); end
      tick();
      checks++;
      if (MemReq !== mPres || AlignError !== mAlign) begin errors++;
        $display("FAIL rnd_req@%0d: got req=%b ae=%b expected %b %b",
                 n, MemReq, AlignError, mPres, mAlign); end
      if (mPres) begin
        checks++;
        if (MemAddr !== mq[0].addr || MemWData !== mq[0].data || MemByteEn !== mq[0].be) begin
          errors++;
          $display("FAIL rnd_head@%0d: got %h %h %b expected %h %h %b", n, MemAddr, MemWData,
                   MemByteEn, mq[0].addr, mq[0].data, mq[0].be); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mPres = 1'b0;
    mAlign = 1'b0;
    drive(0, 2'd0, 0, 0, 0, 0, 0);
    test_reset();
    test_lane_format();
    test_back_to_back();
    test_full_wrap();
    test_misaligned();
    test_load_hazard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-side partner of the load path in the 32-bit MIPS datapath: receives store requests from the MEM stage and writes them to data memory.
- Formats sb/sh/sw data into byte lanes with byte enables and queues stores in a small FIFO.
- Drains the FIFO to data memory over a req/ack handshake so slow memory stalls the pipeline only when the queue is full.
- Stalls loads that hit a queued, unwritten word.

Parameters:
DEPTH, 4, number of queued stores (power of 2, ≥2)
CNT_W, 3, width of Count (log2(DEPTH)+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
MemWrite  in  1  store valid this cycle
StoreSize  in  2  00 byte, 01 half, 10 word, 11 reserved
Address  in  32  store byte address
WriteData  in  32  rt value, data in low bits
MemRead  in  1  load in MEM stage
LoadAddress  in  32  load byte address
StoreAccept  out  1  store enqueued at this edge (combinational)
Stall  out  1  hold pipeline (combinational)
AlignError  out  1  registered one-cycle pulse for a dropped misaligned/reserved store
MemReq  out  1  write request to data memory (registered)
MemAddr  out  32  word-aligned address, [1:0]=00 (registered)
MemWData  out  32  lane-formatted data (registered)
MemByteEn  out  4  byte enables, bit i = byte lane i (registered)
MemAck  in  1  memory accepted current request
Full  out  1  Count==DEPTH
Empty  out  1  Count==0
Count  out  CNT_W  queued entries, including the one being presented

Behaviour:
- Reset: clk and rst_n are fixed as one clock and synchronous active-low reset. While rst_n=0 at an edge:
  - MemReq=0, MemAddr=0, MemWData=0, MemByteEn=0, AlignError=0, Count=0, Empty=1, Full=0, FSM=IDLE.
  - Queued stores are discarded.
  - Reset during an outstanding request drops MemReq after that edge; no ack is awaited.
- Alignment check (little-endian):
  - Misaligned: half with Address[0]=1, word with Address[1:0]≠00, or StoreSize=11.
  - A misaligned store is never enqueued and not stalled; AlignError=1 for the cycle after.
- Lane formatting at enqueue:
  - Byte: data={4{WD[7:0]}}, BE=0001<<Address[1:0].
  - Half: data={2{WD[15:0]}}, BE=Address[1]?1100:0011.
  - Word: data=WD, BE=1111.
  - Stored address = {Address[31:2],2'b00}.
- StoreAccept = MemWrite & aligned & !Full (Full sampled at cycle start).
  - A pop in the same cycle does not free a slot for the push.
  - Simultaneous push and pop when not full leaves Count unchanged.
- Stall = (MemWrite & aligned & Full) | LoadHit.
  - LoadHit = MemRead & some valid entry has addr[31:2]==LoadAddress[31:2]; byte enables are ignored.
  - A load and a store in the same cycle do not compare against each other.
- Drain FSM:
  - IDLE: when !Empty, load the head into MemAddr/MemWData/MemByteEn, set MemReq=1, and go to REQ. Earliest MemReq is one edge after the accepting edge.
  - REQ: MemReq and outputs stay stable until MemAck=1. At the ack edge, pop the head:
    - If entries remain (including a same-edge push), present the next head at that edge and stay in REQ (back-to-back, no bubble).
    - Otherwise MemReq=0 and go to IDLE.
  - MemAck while MemReq=0 is ignored.
- Ordering: stores drain strictly in FIFO order. Pointers wrap modulo DEPTH.

Test Plan:
- Reset mid-request: push sw 0x10/0xDEADBEEF, assert rst_n=0 while MemReq=1, no ack → after the edge MemReq=0, Count=0, Empty=1; no further requests.
- Lane formatting: sb addr 0x103 data 0x000000AB, then sh addr 0x202 data 0x1234, ack each → MemAddr 0x100/WData 0xABABABAB/BE 1000, then MemAddr 0x200/WData 0x12341234/BE 1100.
- Back-to-back drain with MemAck held 1: push sw 0x0, 0x4, 0x8 on consecutive cycles → MemReq high continuously, one request per cycle in order, MemReq=0 after the third ack.
- Full and wrap-around with MemAck=0: push 4 sw → Full=1, Count=4.
  - A 5th push with an ack on the same edge → Stall=1, StoreAccept=0, Count=3 after the edge.
  - Next cycle the push is accepted; drain 8 stores total with correct order across wrap-around.
- Misaligned stores: sw at 0x6, then sh at 0x1 → AlignError pulses one cycle each, Count stays 0, MemReq stays 0.
- Load hazard: queue sw 0x40 with ack withheld; MemRead at LoadAddress 0x42 → Stall=1 until the ack edge, then 0. LoadAddress 0x44 → Stall=0.
